// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, parity-mode constants and frame-length helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  function automatic int frame_len(input int data_bits, input int oversample,
                                   input int stop_bits, input logic par);
    return oversample * (1 + data_bits + int'(par) + stop_bits);
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock FIFO with full/empty flags and occupancy level
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] lvl_q;
  logic          wr_en, rd_en;
  // a push into a full FIFO is allowed only when a pop frees a slot that clock
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign full_o  = lvl_q == LW'(DEPTH);
  assign empty_o = lvl_q == '0;
  assign level_o = lvl_q;
  assign rdata_o = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(wr_en);
      rd_q  <= rd_q + AW'(rd_en);
      lvl_q <= lvl_q + LW'(wr_en) - LW'(rd_en);
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= wdata_i;
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter; define UART_TX_FIFO_EN to add
// a FIFO_DEPTH-word FIFO between the handshake and the frame FSM
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [1:0]                  parity_mode,
  output logic                        busy,
  output logic                        tx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  state_e               state_q, state_d;
  logic [OW-1:0]        os_q, os_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, word;
  logic [1:0]           mode_q, mode_d;
  logic                 par_q, par_d;
  logic                 avail, load, bit_end, last_stop, has_par, queued;
`ifdef UART_TX_FIFO_EN
  logic full, empty;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid && !full),
    .pop_i   (load),
    .wdata_i (tx_data),
    .rdata_o (word),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );
  assign avail    = !empty;
  assign tx_ready = !full;
  assign queued   = !empty;
`else
  assign avail      = tx_valid;
  assign word       = tx_data;
  assign tx_ready   = state_q == IDLE || last_stop;
  assign queued     = 1'b0;
  assign fifo_level = '0;
`endif
  assign bit_end   = os_q == OW'(OVERSAMPLE - 1);
  assign last_stop = state_q == STOP && bit_end && bit_q == BW'(STOP_BITS - 1);
  assign load      = avail && (state_q == IDLE || last_stop);
  assign has_par   = mode_q == PAR_EVEN || mode_q == PAR_ODD;
  assign busy      = state_q != IDLE || queued;
  assign tx        = (state_q == START) ? 1'b0 :
                     (state_q == DATA)  ? shift_q[0] :
                     (state_q == PARITY) ? par_q : 1'b1;
  always_comb begin
    state_d = state_q;
    os_d    = (state_q == IDLE || bit_end) ? '0 : os_q + OW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    mode_d  = mode_q;
    par_d   = par_q;
    case (state_q)
      IDLE:   if (load) state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = (bit_q == BW'(DATA_BITS - 1)) ? '0 : bit_q + BW'(1);
        if (bit_q == BW'(DATA_BITS - 1)) state_d = has_par ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) begin
        bit_d = last_stop ? '0 : bit_q + BW'(1);
        if (last_stop) state_d = load ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // parity is frozen from the loaded word so later input changes cannot leak in
    if (load) begin
      shift_d = word;
      mode_d  = parity_mode;
      par_d   = ^word ^ (parity_mode == PAR_ODD);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      mode_q  <= PAR_NONE;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed frame checks on default and 7-bit/4x/2-stop instances
module tb_uart_tx_param;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n;
  logic [7:0] d0;
  logic [6:0] d1;
  logic       v0, r0, b0, t0, v1, r1, b1, t1;
  logic [1:0] m0, m1;
  logic [2:0] l0, l1;
  logic [7:0] rw;
  bit         rok;
  int         checks = 0, errors = 0;
`ifdef UART_TX_FIFO_EN
  int lv[5] = '{1, 1, 2, 3, 4};
`endif
  uart_tx_param u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(v0), .tx_ready(r0),
    .parity_mode(m0), .busy(b0), .tx(t0), .fifo_level(l0)
  );
  uart_tx_param #(.DATA_BITS(7), .OVERSAMPLE(4), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1), .tx_ready(r1),
    .parity_mode(m1), .busy(b1), .tx(t1), .fifo_level(l1)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic txv(input int d);
    return d != 0 ? t1 : t0;
  endfunction
  function automatic logic busyv(input int d);
    return d != 0 ? b1 : b0;
  endfunction
  task automatic wait_rdy(input int d, input string tag);
    int n;
    n = 0;
    while (!(d != 0 ? r1 : r0) && n < 1000) begin
      tick;
      n++;
    end
    chk({tag, "_ready_seen"}, int'(n < 1000), 1);
  endtask
  task automatic send(input int d, input logic [7:0] w, input logic [1:0] m, input string tag);
    if (d != 0) begin d1 = w[6:0]; m1 = m; v1 = 1'b1; end
    else begin d0 = w; m0 = m; v0 = 1'b1; end
    wait_rdy(d, tag);
    tick;
    if (d != 0) begin v1 = 1'b0; d1 = ~d1; m1 = ~m; end
    else begin v0 = 1'b0; d0 = ~d0; m0 = ~m; end
    chk({tag, "_busy_rise"}, int'(busyv(d)), 1);
    repeat (LAT - 1) tick;
  endtask
  task automatic run_frame(input int d, input int nb, input int os, input logic [15:0] exp,
                           input bit idle_after, input string tag);
    int bz, ok;
    bz = 0;
    for (int b = 0; b < nb; b++) begin
      ok = 0;
      for (int k = 0; k < os; k++) begin
        if (txv(d) == exp[b]) ok++;
        if (busyv(d)) bz++;
        tick;
      end
      chk($sformatf("%s_bit%0d", tag, b), ok, os);
    end
    chk({tag, "_busy_len"}, bz, nb * os);
    if (idle_after) begin
      chk({tag, "_busy_fall"}, int'(busyv(d)), 0);
      chk({tag, "_tx_idle"}, int'(txv(d)), 1);
    end
  endtask
  task automatic rx(output logic [7:0] w, output bit ok);
    int n;
    n = 0;
    w = '0;
    while (t0 && n < 2000) begin
      tick;
      n++;
    end
    ok = n < 2000;
    repeat (8) tick;
    for (int i = 0; i < 8; i++) begin
      repeat (16) tick;
      w[i] = t0;
    end
    repeat (16) tick;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int idle;
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; m0 = 2'd0; m1 = 2'd0;
    repeat (3) tick;
    chk("rst_tx", int'(t0), 1);
    chk("rst_busy", int'(b0), 0);
    chk("rst_ready", int'(r0), 1);
    chk("rst_level", int'(l0), 0);
    chk("rst_tx_u1", int'(t1), 1);
    rst_n = 1'b1;
    tick;
    send(0, 8'hA5, 2'd1, "even");
    run_frame(0, 11, 16, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 1'b1, "even");
    send(0, 8'hA5, 2'd2, "odd");
    run_frame(0, 11, 16, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 1'b1, "odd");
    send(0, 8'hA5, 2'd3, "mode3");
    run_frame(0, 10, 16, {6'b0, 1'b1, 8'hA5, 1'b0}, 1'b1, "mode3");
    send(1, 8'h41, 2'd0, "d7s2");
    run_frame(1, 10, 4, {6'b0, 2'b11, 7'h41, 1'b0}, 1'b1, "d7s2");
    d0 = 8'h00; m0 = 2'd0; v0 = 1'b1;
    wait_rdy(0, "b2b");
    tick;
    d0 = 8'hFF;
`ifdef UART_TX_FIFO_EN
    tick;
    v0 = 1'b0;
`endif
    run_frame(0, 10, 16, {6'b0, 1'b1, 8'h00, 1'b0}, 1'b0, "b2b_first");
    v0 = 1'b0;
    run_frame(0, 10, 16, {6'b0, 1'b1, 8'hFF, 1'b0}, 1'b1, "b2b_second");
`ifdef UART_TX_FIFO_EN
    fork
      begin
        int n;
        for (int i = 0; i < 5; i++) begin
          d0 = 8'(8'h11 * (i + 1));
          v0 = 1'b1;
          wait_rdy(0, $sformatf("fifo_push%0d", i));
          tick;
          chk($sformatf("fifo_level_push%0d", i), int'(l0), lv[i]);
        end
        v0 = 1'b0;
        chk("fifo_full_ready", int'(r0), 0);
        n = 0;
        while (l0 != 3'd3 && n < 1000) begin
          tick;
          n++;
        end
        chk("fifo_ready_after_pop", int'(r0), 1);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          rx(rw, rok);
          chk($sformatf("fifo_rx_found%0d", k), int'(rok), 1);
          chk($sformatf("fifo_rx_word%0d", k), int'(rw), 8'h11 * (k + 1));
          chk($sformatf("fifo_drain%0d", k), int'(l0), 4 - k);
        end
      end
    join
    repeat (20) tick;
`endif
    d0 = 8'h00; m0 = 2'd0; v0 = 1'b1;
    wait_rdy(0, "rstmid");
    tick;
`ifdef UART_TX_FIFO_EN
    tick;
    v0 = 1'b0;
    chk("pre_rst_level", int'(l0), 1);
`endif
    v0 = 1'b0;
    repeat (48) tick;
    chk("pre_rst_tx", int'(t0), 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", int'(t0), 1);
    chk("async_rst_busy", int'(b0), 0);
    chk("async_rst_level", int'(l0), 0);
    tick;
    tick;
    rst_n = 1'b1;
    idle = 0;
    repeat (200) begin
      if (t0 && !b0) idle++;
      tick;
    end
    chk("post_rst_idle", idle, 200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
